// File: rtl/bram_ctrl_param_if.sv
// bram_ctrl_param_if -- valid/ready memory bus between a CPU-side master and
// the block-RAM controller.
//   mem_valid  master -> slave  request valid
//   mem_addr   master -> slave  byte address (bits [1:0] ignored)
//   mem_wdata  master -> slave  write data
//   mem_wstrb  master -> slave  byte-lane enables, 4'b0000 = read
//   mem_ready  slave -> master  one-cycle completion pulse
//   mem_rdata  slave -> master  read data, valid with mem_ready
//   mem_err    slave -> master  out-of-range flag, valid with mem_ready
interface bram_ctrl_param_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata, mem_err
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata, mem_err
   );
endinterface

// File: rtl/bram_ctrl_param.sv
// bram_ctrl_param -- single-port block-RAM controller behind the valid/ready
// memory bus. One transfer at a time: request latched in IDLE, array access
// in ACCESS, optional wait states, then a one-cycle ready pulse.
//   Parameters: ADDR_WIDTH (word-address bits), WAIT_CYCLES (0..15),
//               BASE_ADDR (byte base, aligned to the window size)
//   Ports:      clk      system clock, rising edge
//               reset_n  synchronous active-low reset
//               bus      slave side of bram_ctrl_param_if
//   Macro BRAM_CTRL_INIT_PATTERN_EN: when defined, mem[i] powers up as i;
//   otherwise every word powers up as zero.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for mem_valid; latches the request when it arrives
//   S_ACCESS | array write or read-data load at the end of this cycle
//   S_WAIT   | down-counter burns WAIT_CYCLES cycles
//   S_READY  | mem_ready (and mem_err if out of range) for one cycle
module bram_ctrl_param #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic              clk,
   input logic              reset_n,
   bram_ctrl_param_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   // Window size in bytes, one bit wider so large ADDR_WIDTH cannot overflow.
   localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_READY} state_t;
   typedef logic [31:0] mem_t [DEPTH];

   function automatic mem_t mem_init();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef BRAM_CTRL_INIT_PATTERN_EN
         m[i] = 32'(i);
`else
         m[i] = 32'h0;
`endif
      end
      return m;
   endfunction

   // Contents survive reset; only the power-up image is set here.
   mem_t mem = mem_init();

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  in_range_q, in_range_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  err_q, err_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [31:0]           off;
   logic                  ram_we;

   // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
   assign off = bus.mem_addr - BASE_ADDR;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      in_range_d = in_range_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.mem_valid) begin
               idx_d      = off[ADDR_WIDTH+1:2];
               in_range_d = ({1'b0, off} < WIN_BYTES);
               wdata_d    = bus.mem_wdata;
               wstrb_d    = bus.mem_wstrb;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            err_d = !in_range_q;
            if (wstrb_q == 4'b0000) begin
               rdata_d = in_range_q ? mem[idx_q] : 32'hDEAD_BEEF;
            end
            if (WAIT_CYCLES > 0) begin
               cnt_d   = 4'(WAIT_CYCLES - 1);
               state_d = S_WAIT;
            end else begin
               state_d = S_READY;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_READY;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_READY: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         err_q      <= 1'b0;
         cnt_q      <= 4'h0;
         rdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         in_range_q <= in_range_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
      end
   end

   // Write is gated by reset_n so a reset landing on the ACCESS edge drops it.
   assign ram_we = (state_q == S_ACCESS) && in_range_q && (wstrb_q != 4'b0000) && reset_n;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we && wstrb_q[i]) begin
            mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign bus.mem_ready = (state_q == S_READY);
   assign bus.mem_err   = (state_q == S_READY) && err_q;
   assign bus.mem_rdata = rdata_q;

endmodule

// File: doc/bram_ctrl_param.md
# bram_ctrl_param

Parametrised single-port block-RAM controller behind the core's valid/ready memory bus. It adds configurable depth, base address and wait-state count, plus per-byte write strobes, request latching and an out-of-range error response. The BRAM array is inferred with a registered read. The block sits as a memory-map slave between the CPU bus and on-chip RAM.

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words
- WAIT_CYCLES, 1, extra wait states between access and ready (0..15)
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**ADDR_WIDTH
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- mem_valid  in  1  request valid
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte-lane enables; 4'b0000 = read, any nonzero = write of the enabled lanes
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_err  out  1  asserted with mem_ready when the address was out of range

## Operation
- States: IDLE, ACCESS, WAIT, READY.
- IDLE: when mem_valid=1, latch mem_addr, mem_wdata and mem_wstrb, compute the in-range flag, and go to ACCESS. Later bus changes do not affect the transfer.
- In-range test: (addr - BASE_ADDR) < 4*2**ADDR_WIDTH, using unsigned 32-bit arithmetic. Word index = (addr - BASE_ADDR)[ADDR_WIDTH+1:2].
- ACCESS, in range:
  - Write: each lane i with wstrb[i]=1 gets wdata[8i+7:8i]; other lanes are unchanged. mem_rdata is not reloaded.
  - Read: mem_rdata <= mem[index].
- ACCESS, out of range:
  - No array write.
  - A read loads mem_rdata <= 32'hDEAD_BEEF.
  - The error flag is set.
- After ACCESS: go to WAIT if WAIT_CYCLES>0, otherwise go to READY. A down-counter loaded with WAIT_CYCLES-1 leaves WAIT at zero.
- READY: mem_ready=1 and mem_err=error flag for exactly one cycle, then return to IDLE.
- mem_valid is ignored outside IDLE. A master that still holds mem_valid=1 in the IDLE cycle after READY starts a new transfer.
- mem_rdata holds its last loaded value until the next read ACCESS.
- Reset values: state IDLE, mem_ready 0, mem_err 0, mem_rdata 32'h0, counter 0.
- Reset mid-transfer: state returns to IDLE and no ready is issued. A write whose ACCESS edge has reset_n=0 is suppressed. Array contents are never cleared by reset.

## Timing
- Cycle 0 is the first cycle in which mem_valid=1 is sampled in IDLE.
- ACCESS is cycle 1; the array operation and the rdata load occur at the end of cycle 1.
- mem_ready=1 in cycle 2+WAIT_CYCLES. With the default, that is cycle 3.
- Minimum request-to-request spacing is 3+WAIT_CYCLES cycles.
- Read-after-write to the same word in the next transfer returns the new data; no hazard is possible.
- Outputs are registered or state-decoded only; there is no combinational path from mem_* inputs to outputs.

## Configuration
- BRAM_CTRL_INIT_PATTERN_EN
  - Defined: the array is initialised so that mem[i] = i (32-bit) for every word. This supports simulation and FPGA bring-up.
  - Undefined: all words are initialised to 32'h0.
- Bus behaviour is identical in both cases.

## Test plan
Default parameters, BRAM_CTRL_INIT_PATTERN_EN defined:
- Read: read addr 0x10 -> mem_ready exactly in cycle 3 for one cycle; mem_rdata=0x0000_0004; mem_err=0.
- Full-word write: write 0xAABB_CCDD, wstrb 4'b1111, to 0x80, then read 0x80 -> 0xAABB_CCDD. The write's own ready is in cycle 3.
- Byte-lane write: write wdata 0x0000_5500, wstrb 4'b0010, to 0x84 (initial 0x21), then read -> 0x0000_5521.
- Out of range: read 0x1000 -> ready with mem_err=1 and rdata 0xDEAD_BEEF. Then write 0x1234 to 0x1000 and read 0x0 -> 0x0000_0000 (no aliasing).
- Reset during ACCESS: write 0xFFFF_FFFF to 0x88 with reset_n=0 in cycle 1 -> no mem_ready. After release, read 0x88 -> 0x0000_0022.
- WAIT_CYCLES sweep: WAIT_CYCLES=0 and WAIT_CYCLES=3 -> ready in cycle 2 and cycle 5 respectively. With mem_valid held high, the next ready follows 3+WAIT_CYCLES cycles later.
